jtag_dmi_apb_master: RTL and testbench
======================================

// Module: jtag_dmi_apb_master
// PURPOSE
//  Sequences DMI requests from the JTAG data-register path onto an APB bus. It is the APB master behind jtag_top.
//  - One request per dmi_transfer pulse.
//  - Read data returns to jtag_top.dmi_data_in.
//  - Completion status is kept for the next DMI scan.
//  - Overlapping scans, slave errors and hung slaves are handled in a defined way.
// PARAMETERS
//  DWIDTH      32   DMI/APB data width
//  AWIDTH      32   DMI/APB address width
//  TIMEOUT     255  max ACCESS cycles waiting for PREADY before abort (>=1)
// PORTS
//  TCK            in   1       sole clock, all flops posedge
//  TRST           in   1       asynchronous active-low reset
//  dmi_transfer   in   1       1-cycle request strobe from DR update
//  dmi_op_in      in   2       0=NOP 1=READ 2=WRITE 3=RESERVED
//  dmi_addr_in    in   AWIDTH  request address
//  dmi_wdata_in   in   DWIDTH  request write data
//  dmi_reset      in   1       clears sticky status (DTMCS dmireset)
//  rd_data_out    out  DWIDTH  last read data -> jtag_top.dmi_data_in
//  dmi_status     out  2       0=OK 2=FAILED 3=BUSY (sticky)
//  busy           out  1       transaction in flight
//  PSEL/PENABLE/PWRITE  out 1  APB control
//  PADDR          out  AWIDTH  APB address
//  PWDATA         out  DWIDTH  APB write data
//  PRDATA         in   DWIDTH  APB read data
//  PREADY         in   1       APB ready
//  PSLVERR        in   1       APB slave error
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, timeout counter 0.
//   - TRST low mid-transfer drops PSEL/PENABLE asynchronously; no completion is recorded.
//  FSM states: IDLE, SETUP, ACCESS.
//  IDLE
//   - dmi_transfer with op READ/WRITE and dmi_status==0:
//     latch addr, wdata and PWRITE=(op==2); go to SETUP.
//   - op NOP: no bus activity, status unchanged.
//   - op RESERVED: dmi_status<=2, stay IDLE.
//   - dmi_status!=0: request ignored, status unchanged.
//  SETUP
//   - PSEL=1, PENABLE=0; next cycle always ACCESS.
//  ACCESS
//   - PSEL=1, PENABLE=1; timeout counter increments each cycle.
//   - PREADY=1, PSLVERR=0: complete; on READ rd_data_out<=PRDATA on the same edge; -> IDLE.
//   - PREADY=1, PSLVERR=1: dmi_status<=2, rd_data_out unchanged; -> IDLE.
//   - Counter reaches TIMEOUT with PREADY=0: dmi_status<=2, drop PSEL/PENABLE; -> IDLE.
//  Latency: strobe at edge N -> SETUP at N+1 -> ACCESS at N+2.
//   - Zero-wait slave completes at edge N+3; IDLE again from N+3.
//  busy = (state!=IDLE).
//  PADDR, PWDATA and PWRITE hold stable from SETUP through the end of ACCESS.
//  dmi_transfer while busy: request dropped, dmi_status<=3 unless already 2 (FAILED wins);
//   the in-flight transfer completes normally.
//  dmi_reset=1: dmi_status<=0 in any state; does not abort the bus cycle.
//   - Same cycle as an error or busy set: dmi_reset wins.
//  Timeout counter is $clog2(TIMEOUT+1) bits, cleared on entry to SETUP, never wraps.
// STRUCTURE
//  Shared defines, in the jtag include header used by jtag_data_register:
//   - DMI op codes
//   - status codes OK/FAILED/BUSY
//   - FSM state encodings
//  No sub-module: FSM, latches and timeout counter in one file.
//  Instantiated beside jtag_top; jtag_top's dmi_* outputs feed this block's dmi_* inputs.
// TESTING
//  1 WRITE a=0x10 d=0xDEADBEEF, PREADY=1 -> PSEL@N+1, PENABLE@N+2, PWRITE=1, PWDATA=0xDEADBEEF, status 0.
//  2 READ a=0x04, PREADY low 3 cycles, PRDATA=0x12345678 -> rd_data_out=0x12345678 at N+6, busy 5 cycles.
//  3 READ with PSLVERR=1 -> status 2; next WRITE ignored (no PSEL); dmi_reset -> status 0; retry succeeds.
//  4 PREADY held 0, TIMEOUT=4 -> PSEL drops after 4 ACCESS cycles, status 2.
//  5 Second dmi_transfer during ACCESS -> first completes, status 3, no second bus cycle; op 3 -> status 2.
//  6 TRST low during ACCESS -> PSEL/PENABLE 0 immediately, rd_data_out 0, status 0 after release.

Source files
------------

// File: rtl/jtag_dmi_apb_master_pkg.sv
// Shared DMI op codes, sticky status codes and APB sequencer state encodings
// for the JTAG debug-module-interface APB master.
package jtag_dmi_apb_master_pkg;

    typedef enum logic [1:0] {
        DMI_OP_NOP   = 2'd0,
        DMI_OP_READ  = 2'd1,
        DMI_OP_WRITE = 2'd2,
        DMI_OP_RSVD  = 2'd3
    } dmi_op_e;

    typedef enum logic [1:0] {
        DMI_OK     = 2'd0,
        DMI_FAILED = 2'd2,
        DMI_BUSY   = 2'd3
    } dmi_status_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/jtag_dmi_apb_master.sv
// APB master that turns one DMI request per dmi_transfer strobe into an APB
// SETUP/ACCESS cycle, with sticky completion status and a hung-slave timeout.
module jtag_dmi_apb_master
    import jtag_dmi_apb_master_pkg::*;
#(
    parameter int DWIDTH  = 32,
    parameter int AWIDTH  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              TCK,
    input  logic              TRST,
    input  logic              dmi_transfer,
    input  logic [1:0]        dmi_op_in,
    input  logic [AWIDTH-1:0] dmi_addr_in,
    input  logic [DWIDTH-1:0] dmi_wdata_in,
    input  logic              dmi_reset,
    output logic [DWIDTH-1:0] rd_data_out,
    output logic [1:0]        dmi_status,
    output logic              busy,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [AWIDTH-1:0] PADDR,
    output logic [DWIDTH-1:0] PWDATA,
    input  logic [DWIDTH-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

    apb_state_e        state_q, state_d;
    dmi_status_e       status_q, status_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic              write_q, write_d;

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            state_q  <= ST_IDLE;
            status_q <= DMI_OK;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            write_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            write_q  <= write_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        write_d  = write_q;

        case (state_q)
            ST_IDLE: begin
                if (dmi_transfer) begin
                    case (dmi_op_in)
                        DMI_OP_READ, DMI_OP_WRITE: begin
                            if (status_q == DMI_OK) begin
                                addr_d  = dmi_addr_in;
                                wdata_d = dmi_wdata_in;
                                write_d = (dmi_op_in == DMI_OP_WRITE);
                                cnt_d   = '0;
                                state_d = ST_SETUP;
                            end
                        end
                        DMI_OP_RSVD: status_d = DMI_FAILED;
                        default: ;
                    endcase
                end
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                // Saturate so a slow slave can never wrap the counter back to zero.
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (PREADY) begin
                    state_d = ST_IDLE;
                    if (PSLVERR) begin
                        status_d = DMI_FAILED;
                    end else if (!write_q) begin
                        rdata_d = PRDATA;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = ST_IDLE;
                    status_d = DMI_FAILED;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A strobe arriving mid-transfer is dropped; FAILED must never be downgraded to BUSY.
        if (dmi_transfer && (state_q != ST_IDLE) && (status_d != DMI_FAILED)) begin
            status_d = DMI_BUSY;
        end
        if (dmi_reset) begin
            status_d = DMI_OK;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign PSEL        = (state_q != ST_IDLE);
    assign PENABLE     = (state_q == ST_ACCESS);
    assign PWRITE      = write_q;
    assign PADDR       = addr_q;
    assign PWDATA      = wdata_q;
    assign rd_data_out = rdata_q;
    assign dmi_status  = status_q;

endmodule

// File: tb/tb_jtag_dmi_apb_master.sv
// Directed bench for jtag_dmi_apb_master: a transaction-level model checked
// every falling edge, plus hand-computed checks at known cycle offsets.
module tb_jtag_dmi_apb_master;

    localparam int TO = 4;

    logic        TCK = 1'b0;
    logic        TRST;
    logic        dmi_transfer;
    logic [1:0]  dmi_op_in;
    logic [31:0] dmi_addr_in;
    logic [31:0] dmi_wdata_in;
    logic        dmi_reset;
    logic [31:0] rd_data_out;
    logic [1:0]  dmi_status;
    logic        busy;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int checkCount = 0;
    int failCount  = 0;

    // Slave behaviour knobs
    int slaveWait  = 0;
    bit slaveErr   = 1'b0;
    bit slaveHang  = 1'b0;
    int accessSeen = 0;

    // Model state: transaction in flight and its age in cycles since acceptance
    bit          mInFlight = 1'b0;
    int          mAge      = 0;
    bit          mWrite    = 1'b0;
    logic [31:0] mAddr     = '0;
    logic [31:0] mWdata    = '0;
    logic [31:0] mRdata    = '0;
    logic [1:0]  mStatus   = '0;

    jtag_dmi_apb_master #(.DWIDTH(32), .AWIDTH(32), .TIMEOUT(TO)) dut (
        .TCK(TCK), .TRST(TRST),
        .dmi_transfer(dmi_transfer), .dmi_op_in(dmi_op_in),
        .dmi_addr_in(dmi_addr_in), .dmi_wdata_in(dmi_wdata_in),
        .dmi_reset(dmi_reset),
        .rd_data_out(rd_data_out), .dmi_status(dmi_status), .busy(busy),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 TCK = ~TCK;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge TCK);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        dmi_op_in    = op;
        dmi_addr_in  = addr;
        dmi_wdata_in = wdata;
        dmi_transfer = 1'b1;
        tick();
        dmi_transfer = 1'b0;
    endtask

    task automatic pulseDmiReset();
        dmi_reset = 1'b1;
        tick();
        dmi_reset = 1'b0;
    endtask

    // Slave: ready after slaveWait wait states of ACCESS, decided away from the clock edge
    initial begin
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        forever begin
            @(negedge TCK);
            if (PSEL && PENABLE) accessSeen++;
            else accessSeen = 0;
            PREADY  = !slaveHang && (accessSeen > slaveWait);
            PSLVERR = PREADY && slaveErr;
        end
    end

    // Transaction-level model: SETUP is age 1, ACCESS cycle k is age k+1
    initial begin
        bit done, err, busyHit;
        forever begin
            @(posedge TCK or negedge TRST);
            if (!TRST) begin
                mInFlight = 1'b0; mAge = 0; mWrite = 1'b0;
                mAddr = '0; mWdata = '0; mRdata = '0; mStatus = '0;
            end else begin
                done = 1'b0; err = 1'b0; busyHit = 1'b0;
                if (mInFlight) begin
                    if (mAge >= 2) begin
                        if (PREADY) begin
                            done = 1'b1;
                            if (PSLVERR) err = 1'b1;
                            else if (!mWrite) mRdata = PRDATA;
                        end else if (mAge - 1 == TO) begin
                            done = 1'b1;
                            err  = 1'b1;
                        end
                    end
                    if (dmi_transfer) busyHit = 1'b1;
                    if (done) mInFlight = 1'b0;
                    else mAge++;
                end else if (dmi_transfer) begin
                    if (dmi_op_in == 2'd3) begin
                        err = 1'b1;
                    end else if (dmi_op_in != 2'd0 && mStatus == 2'd0) begin
                        mInFlight = 1'b1;
                        mAge      = 1;
                        mWrite    = (dmi_op_in == 2'd2);
                        mAddr     = dmi_addr_in;
                        mWdata    = dmi_wdata_in;
                    end
                end
                if (dmi_reset) mStatus = 2'd0;
                else if (err) mStatus = 2'd2;
                else if (busyHit && mStatus != 2'd2) mStatus = 2'd3;
            end
        end
    end

    // Compare process
    initial begin
        forever begin
            @(negedge TCK);
            if (!TRST) begin
                checkOutput("rstPsel", {31'b0, PSEL}, 32'd0);
                checkOutput("rstPenable", {31'b0, PENABLE}, 32'd0);
                checkOutput("rstRdata", rd_data_out, 32'd0);
                checkOutput("rstStatus", {30'b0, dmi_status}, 32'd0);
            end else begin
                checkOutput("busy", {31'b0, busy}, {31'b0, mInFlight});
                checkOutput("psel", {31'b0, PSEL}, {31'b0, mInFlight});
                checkOutput("penable", {31'b0, PENABLE}, {31'b0, mInFlight && mAge >= 2});
                checkOutput("rdData", rd_data_out, mRdata);
                checkOutput("status", {30'b0, dmi_status}, {30'b0, mStatus});
                if (mInFlight) begin
                    checkOutput("paddr", PADDR, mAddr);
                    checkOutput("pwdata", PWDATA, mWdata);
                    checkOutput("pwrite", {31'b0, PWRITE}, {31'b0, mWrite});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] simulation hung");
    end

    initial begin
        int cnt;
        TRST = 1'b0; dmi_transfer = 1'b0; dmi_op_in = 2'd0;
        dmi_addr_in = '0; dmi_wdata_in = '0; dmi_reset = 1'b0; PRDATA = '0;
        #3;
        checkOutput("resetPsel", {31'b0, PSEL}, 32'd0);
        checkOutput("resetBusy", {31'b0, busy}, 32'd0);
        checkOutput("resetPaddr", PADDR, 32'd0);
        checkOutput("resetStatus", {30'b0, dmi_status}, 32'd0);
        @(posedge TCK); #1;
        TRST = 1'b1;
        tick(2);

        // 1: zero-wait WRITE
        $display("[TB] test 1 write");
        applyStimulus(2'd2, 32'h10, 32'hDEADBEEF);
        checkOutput("t1SetupPsel", {31'b0, PSEL}, 32'd1);
        checkOutput("t1SetupPenable", {31'b0, PENABLE}, 32'd0);
        checkOutput("t1Paddr", PADDR, 32'h10);
        tick();
        checkOutput("t1AccessPenable", {31'b0, PENABLE}, 32'd1);
        checkOutput("t1Pwrite", {31'b0, PWRITE}, 32'd1);
        checkOutput("t1Pwdata", PWDATA, 32'hDEADBEEF);
        tick();
        checkOutput("t1DoneBusy", {31'b0, busy}, 32'd0);
        checkOutput("t1Status", {30'b0, dmi_status}, 32'd0);

        // 2: READ with three wait states
        $display("[TB] test 2 read with wait states");
        PRDATA = 32'h12345678; slaveWait = 3;
        applyStimulus(2'd1, 32'h04, 32'h0);
        cnt = 0;
        for (int i = 0; i < 20 && busy; i++) begin
            cnt++;
            tick();
        end
        checkOutput("t2BusyCycles", cnt, 32'd5);
        checkOutput("t2RdData", rd_data_out, 32'h12345678);

        // 3: slave error, blocked request, dmireset, retry
        $display("[TB] test 3 slave error");
        PRDATA = 32'hCAFEF00D; slaveWait = 0; slaveErr = 1'b1;
        applyStimulus(2'd1, 32'h08, 32'h0);
        tick(2);
        checkOutput("t3Status", {30'b0, dmi_status}, 32'd2);
        checkOutput("t3RdKept", rd_data_out, 32'h12345678);
        slaveErr = 1'b0;
        applyStimulus(2'd2, 32'h20, 32'h55);
        checkOutput("t3Ignored", {31'b0, PSEL}, 32'd0);
        pulseDmiReset();
        checkOutput("t3Cleared", {30'b0, dmi_status}, 32'd0);
        applyStimulus(2'd2, 32'h20, 32'h55);
        checkOutput("t3RetryPsel", {31'b0, PSEL}, 32'd1);
        tick(2);
        checkOutput("t3RetryStatus", {30'b0, dmi_status}, 32'd0);

        // 4: hung slave, TIMEOUT=4
        $display("[TB] test 4 timeout");
        slaveHang = 1'b1;
        applyStimulus(2'd1, 32'h30, 32'h0);
        tick();
        cnt = 0;
        for (int i = 0; i < 20 && PENABLE; i++) begin
            cnt++;
            tick();
        end
        checkOutput("t4AccessCycles", cnt, 32'd4);
        checkOutput("t4Psel", {31'b0, PSEL}, 32'd0);
        checkOutput("t4Status", {30'b0, dmi_status}, 32'd2);
        slaveHang = 1'b0;
        pulseDmiReset();

        // 5: overlapping request, then reserved op
        $display("[TB] test 5 overlap");
        slaveWait = 2;
        applyStimulus(2'd2, 32'h40, 32'h1111);
        tick();
        applyStimulus(2'd1, 32'h44, 32'hAAAA);
        checkOutput("t5Status", {30'b0, dmi_status}, 32'd3);
        checkOutput("t5PaddrHeld", PADDR, 32'h40);
        for (int i = 0; i < 20 && busy; i++) tick();
        tick(3);
        checkOutput("t5NoSecond", {31'b0, PSEL}, 32'd0);
        checkOutput("t5StatusKept", {30'b0, dmi_status}, 32'd3);
        applyStimulus(2'd3, 32'h0, 32'h0);
        checkOutput("t5Reserved", {30'b0, dmi_status}, 32'd2);
        pulseDmiReset();

        // 6: TRST during ACCESS
        $display("[TB] test 6 reset mid-transfer");
        PRDATA = 32'h0BADF00D; slaveWait = 3;
        applyStimulus(2'd1, 32'h50, 32'h0);
        tick();
        #2 TRST = 1'b0;
        #1;
        checkOutput("t6Psel", {31'b0, PSEL}, 32'd0);
        checkOutput("t6Penable", {31'b0, PENABLE}, 32'd0);
        checkOutput("t6RdData", rd_data_out, 32'd0);
        @(posedge TCK); #1;
        TRST = 1'b1;
        tick();
        checkOutput("t6Status", {30'b0, dmi_status}, 32'd0);
        slaveWait = 0;
        applyStimulus(2'd1, 32'h54, 32'h0);
        tick(2);
        checkOutput("t6Recover", rd_data_out, 32'h0BADF00D);
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
